recip_normalizer: RTL and testbench
===================================

# recip_normalizer

Iterative range-reduction stage that sits directly upstream of the fixed-point CORDIC reciprocal core. It takes a signed fixed-point operand and splits it into a sign, a magnitude normalised into [1,2), and a signed power-of-two shift. The normalised magnitude is what feeds the core's `x`, which keeps linear-mode CORDIC inside its convergence range. Sign and shift travel alongside so a downstream stage can rebuild 1/x = ±(1/m)·2^-shift.

## Interface
- `FLOAT_SIZE`, 24, fractional bits of the Q format
- `INT_SIZE`, 8, integer bits including sign; W = INT_SIZE+FLOAT_SIZE
- `clk` input 1, sole clock, rising edge
- `rst` input 1, reset; synchronous, active-high
- `in_valid` input 1, operand offered
- `in_ready` output 1, block can accept; equals (state==IDLE)
- `x` input W, signed operand, Q(INT_SIZE).(FLOAT_SIZE)
- `out_valid` output 1, result held
- `out_ready` input 1, consumer takes result
- `m_out` output W, unsigned normalised magnitude, same Q format; bit FLOAT_SIZE set unless zero
- `shift_out` output SHIFT_W = $clog2(W)+1, signed shift; |x| = m_out·2^shift_out
- `sign_out` output 1, sign of `x`
- `zero_out` output 1, `x` was zero

## Operation
- States: IDLE, SCAN, HOLD.
- IDLE → SCAN on in_valid && in_ready.
  - Capture sign = x[W-1].
  - Capture mag = |x| as unsigned W bits. The most negative input gives 2^(INT_SIZE-1), which is representable unsigned.
  - Clear the shift counter.
- Each SCAN cycle:
  - If mag==0: go to HOLD with zero_out=1, m_out=0, shift_out=0.
  - Else if the leading one is at bit FLOAT_SIZE: go to HOLD.
  - Else if the leading one is above FLOAT_SIZE: mag >>= 1 (LSB truncated), shift += 1.
  - Else: mag <<= 1, shift -= 1.
- Shift range:
  - Left shifts: at most FLOAT_SIZE.
  - Right shifts: at most INT_SIZE-1.
  - shift_out never wraps.
- HOLD: out_valid=1. Outputs are stable until out_valid && out_ready, then the block returns to IDLE.
- Inputs are ignored outside IDLE. in_valid while busy is not queued.

## Timing
- Reset value of every output is 0 (in_ready, out_valid, m_out, shift_out, sign_out, zero_out).
- in_ready reads 1 from the first cycle after rst deasserts.
- Latency: out_valid rises N+1 edges after the accepting edge, where N is the number of shift cycles.
  - Already-normalised or zero operand: 1 edge.
  - Worst case, 1 LSB operand: FLOAT_SIZE+1 edges.
- Handshake completes in HOLD. in_ready rises on the following cycle, so there is a one-cycle bubble and no same-cycle bypass. Throughput is one operand per N+3 cycles.
- out_ready while not in HOLD has no effect.
- rst asserted in any state:
  - Aborts the operation and returns to IDLE.
  - Clears all outputs.
  - No out_valid is produced for the aborted operand.

## Configuration
- `RECIP_NORM_FAST_EN` defined: each SCAN cycle may shift by 4.
  - Left by 4 when bits [W-1:FLOAT_SIZE-3] are all zero.
  - Right by 4 when any bit of [W-1:FLOAT_SIZE+4] is set.
  - Otherwise shift by 1 as above.
  - Worst-case latency is ceil(FLOAT_SIZE/4)+1 edges. Results are bit-identical to the undefined case.
- Undefined: one bit per SCAN cycle only.

## Structure
- Shared package `recip_pkg` holds:
  - the state enum (IDLE/SCAN/HOLD);
  - the SHIFT_W width function;
  - default FLOAT_SIZE/INT_SIZE constants, shared with the reciprocal core and the downstream denormaliser.
- One combinational sub-module, `recip_norm_step`, takes mag and returns the next mag, the shift delta and a done/zero flag. The FAST_EN variant lives inside it.

## Test plan
All values are Q8.24, listed as x → m_out / shift_out / sign_out / zero_out.

- x=0x01000000 (1.0) → 0x01000000 / 0 / 0 / 0. out_valid 1 edge after accept.
- x=0xFA000000 (-6.0) → 0x01800000 / +2 / 1 / 0. Latency 3.
- x=0x00400000 (0.25) → 0x01000000 / -2 / 0 / 0.
- x=0x00000001 → 0x01000000 / -24. Latency 25, or 7 with `RECIP_NORM_FAST_EN`.
- x=0x80000000 (-128) → 0x01000000 / +7 / 1 / 0.
- x=0 → zero_out=1, m_out=0, shift_out=0, latency 1.
- Backpressure: hold out_ready low for 5 cycles → outputs stable and a new in_valid ignored. Release → in_ready returns the next cycle.
- Reset mid-op: assert rst during SCAN → all outputs 0, out_valid never rises, the next operand processes correctly.

Source files
------------

// File: rtl/recip_pkg.sv
// ============================================================================
// recip_pkg : shared types and constants for the reciprocal datapath
// Revision  : 1.0
// ============================================================================
`default_nettype none

package recip_pkg;

  localparam int DEF_FLOAT_SIZE = 24;
  localparam int DEF_INT_SIZE   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Signed shift width: covers -FLOAT_SIZE .. +(INT_SIZE-1) without wrap.
  function automatic int shift_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/recip_norm_step.sv
// ============================================================================
// recip_norm_step : one combinational normalisation step toward [1,2)
// Optional macro  : RECIP_NORM_FAST_EN (allows 4-bit steps)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module recip_norm_step
  import recip_pkg::*;
#(
  parameter int FLOAT_SIZE = DEF_FLOAT_SIZE,
  parameter int INT_SIZE   = DEF_INT_SIZE,
  localparam int W         = INT_SIZE + FLOAT_SIZE
) (
  input  logic [W-1:0]      mag_i,
  output logic [W-1:0]      mag_o,
  output logic signed [3:0] delta_o,
  output logic              done_o,
  output logic              zero_o
);

  logic w_above;
  logic w_at;

  assign w_above = |mag_i[W-1:FLOAT_SIZE+1];
  assign w_at    = mag_i[FLOAT_SIZE];
  assign zero_o  = (mag_i == '0);

  always_comb begin
    mag_o   = mag_i;
    delta_o = 4'sd0;
    done_o  = 1'b0;
    if (zero_o) begin
      done_o = 1'b1;
    end else if (w_above) begin
`ifdef RECIP_NORM_FAST_EN
      if (|mag_i[W-1:FLOAT_SIZE+4]) begin
        mag_o   = mag_i >> 4;
        delta_o = 4'sd4;
      end else begin
        mag_o   = mag_i >> 1;
        delta_o = 4'sd1;
      end
`else
      mag_o   = mag_i >> 1;
      delta_o = 4'sd1;
`endif
    end else if (w_at) begin
      done_o = 1'b1;
    end else begin
`ifdef RECIP_NORM_FAST_EN
      // Leading one at or below FLOAT_SIZE-4: a 4-bit jump cannot overshoot.
      if (~|mag_i[W-1:FLOAT_SIZE-3]) begin
        mag_o   = mag_i << 4;
        delta_o = -4'sd4;
      end else begin
        mag_o   = mag_i << 1;
        delta_o = -4'sd1;
      end
`else
      mag_o   = mag_i << 1;
      delta_o = -4'sd1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/recip_normalizer.sv
// ============================================================================
// recip_normalizer : splits a signed Qm.n operand into sign, [1,2) magnitude
//                    and signed power-of-two shift. Macro: RECIP_NORM_FAST_EN
// Revision         : 1.0
// ============================================================================
`default_nettype none

module recip_normalizer
  import recip_pkg::*;
#(
  parameter int FLOAT_SIZE = DEF_FLOAT_SIZE,
  parameter int INT_SIZE   = DEF_INT_SIZE,
  localparam int W         = INT_SIZE + FLOAT_SIZE,
  localparam int SHIFT_W   = shift_w(W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              m_out,
  output logic signed [SHIFT_W-1:0] shift_out,
  output logic                      sign_out,
  output logic                      zero_out
);

  state_e                    state_q, state_d;
  logic [W-1:0]              mag_q, mag_d;
  logic signed [SHIFT_W-1:0] shift_q, shift_d;
  logic                      sign_q, sign_d;
  logic                      zero_q, zero_d;

  logic [W-1:0]              w_step_mag;
  logic signed [3:0]         w_step_delta;
  logic                      w_step_done;
  logic                      w_step_zero;
  logic [W-1:0]              w_abs_x;

  recip_norm_step #(
    .FLOAT_SIZE (FLOAT_SIZE),
    .INT_SIZE   (INT_SIZE)
  ) u_step (
    .mag_i   (mag_q),
    .mag_o   (w_step_mag),
    .delta_o (w_step_delta),
    .done_o  (w_step_done),
    .zero_o  (w_step_zero)
  );

  // Most negative input maps to 2^(W-1), which still fits unsigned.
  assign w_abs_x = x[W-1] ? (~x + W'(1)) : x;

  // Gated by rst so in_ready reads 0 while reset is held.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == HOLD);
  assign m_out     = mag_q;
  assign shift_out = shift_q;
  assign sign_out  = sign_q;
  assign zero_out  = zero_q;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    shift_d = shift_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = x[W-1];
          mag_d   = w_abs_x;
          shift_d = '0;
          zero_d  = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (w_step_done) begin
          zero_d  = w_step_zero;
          state_d = HOLD;
        end else begin
          mag_d   = w_step_mag;
          shift_d = shift_q + SHIFT_W'(w_step_delta);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      shift_q <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      shift_q <= shift_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_recip_normalizer.sv
// ============================================================================
// tb_recip_normalizer : directed self-checking bench for recip_normalizer
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_recip_normalizer;

  localparam int W  = 32;
  localparam int SW = 6;

`ifdef RECIP_NORM_FAST_EN
  localparam int LAT_ONE_LSB = 7;
  localparam int LAT_M128    = 5;
`else
  localparam int LAT_ONE_LSB = 25;
  localparam int LAT_M128    = 8;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  m_out;
  logic [SW-1:0] shift_out;
  logic          sign_out;
  logic          zero_out;

  int checks   = 0;
  int failures = 0;
  int lat;
  int seen;

  recip_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m_out     (m_out),
    .shift_out (shift_out),
    .sign_out  (sign_out),
    .zero_out  (zero_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand at the negedge; return edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] xv, output int l);
    @(negedge clk);
    chk("in_ready_before_op", 64'(in_ready), 64'd1);
    x        = xv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    l = 0;
    while (l < 40) begin
      @(posedge clk);
      #1;
      l++;
      if (out_valid) break;
    end
    chk("out_valid_within_bound", 64'(out_valid), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] em,
                              input logic [SW-1:0] es, input logic esg, input logic ez);
    chk({tag, "_m"},     64'(m_out),     64'(em));
    chk({tag, "_shift"}, 64'(shift_out), 64'(es));
    chk({tag, "_sign"},  64'(sign_out),  64'(esg));
    chk({tag, "_zero"},  64'(zero_out),  64'(ez));
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", 64'(out_valid), 64'd0);
    chk("in_ready_after_take",  64'(in_ready),  64'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_m_out",     64'(m_out),     64'd0);
    chk("rst_shift",     64'(shift_out), 64'd0);
    chk("rst_sign",      64'(sign_out),  64'd0);
    chk("rst_zero",      64'(zero_out),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // 1.0: already normalised
    run_op(32'h0100_0000, lat);
    chk("lat_one", 64'(lat), 64'd1);
    check_result("one", 32'h0100_0000, 6'h00, 1'b0, 1'b0);
    consume();

    // -6.0
    run_op(32'hFA00_0000, lat);
    chk("lat_m6", 64'(lat), 64'd3);
    check_result("m6", 32'h0180_0000, 6'h02, 1'b1, 1'b0);
    consume();

    // 0.25
    run_op(32'h0040_0000, lat);
    chk("lat_quarter", 64'(lat), 64'd3);
    check_result("quarter", 32'h0100_0000, 6'h3E, 1'b0, 1'b0);
    consume();

    // 1 LSB: worst-case left shift
    run_op(32'h0000_0001, lat);
    chk("lat_lsb", 64'(lat), 64'(LAT_ONE_LSB));
    check_result("lsb", 32'h0100_0000, 6'h28, 1'b0, 1'b0);
    consume();

    // Most negative operand
    run_op(32'h8000_0000, lat);
    chk("lat_m128", 64'(lat), 64'(LAT_M128));
    check_result("m128", 32'h0100_0000, 6'h07, 1'b1, 1'b0);
    consume();

    // Zero
    run_op(32'h0000_0000, lat);
    chk("lat_zero", 64'(lat), 64'd1);
    check_result("zero", 32'h0000_0000, 6'h00, 1'b0, 1'b1);
    consume();

    // Backpressure with a competing operand offered while busy
    run_op(32'hFA00_0000, lat);
    @(negedge clk);
    x        = 32'h0100_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      check_result("bp", 32'h0180_0000, 6'h02, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    consume();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("bp_no_queued_op", 64'(seen), 64'd0);

    // Reset mid-operation
    run_op(32'hFFFF_FFFF, lat);
    consume();
    @(negedge clk);
    x        = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_m_out",     64'(m_out),     64'd0);
    chk("midrst_shift",     64'(shift_out), 64'd0);
    chk("midrst_sign",      64'(sign_out),  64'd0);
    chk("midrst_zero",      64'(zero_out),  64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);

    run_op(32'h0040_0000, lat);
    chk("post_rst_lat", 64'(lat), 64'd3);
    check_result("post_rst", 32'h0100_0000, 6'h3E, 1'b0, 1'b0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
